// File: rtl/ballot_controller.sv
// Purpose : voting-machine ballot FSM (IDLE/ARMED/COMMIT/LOCKED/REVIEW) with timeout, reject, tally and result scan.
// Latency : legal vote sampled at edge N -> vote_inc in cycle N+1 -> updated ballots from cycle N+2; all outputs registered.
// Backpres: none; button levels are sampled every cycle, LOCKED waits for all buttons released before re-opening.
module ballot_controller #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int SCAN_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       arm,
    input  logic [3:0] valid_vote,
    output logic [3:0] vote_inc,
    output logic       ballot_ready,
    output logic       reject,
    output logic       timeout,
    output logic [1:0] rd_sel,
    output logic       rd_valid,
    output logic [7:0] ballots
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_REVIEW = 3'd4;

    // Terminal counts; both parameters are bounded to 16 bits.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] timer;
    logic [15:0] timer_nxt;
    logic [15:0] scan_cnt;
    logic [15:0] scan_nxt;
    logic [1:0]  sel_nxt;
    logic [3:0]  inc_nxt;
    logic        rej_nxt;
    logic        tmo_nxt;
    logic [7:0]  ballots_nxt;

    logic        vote_any;
    logic        vote_one;
    logic        vote_multi;

    // Classify the button pattern: none, exactly one (legal), or several (illegal).
    always_comb begin
        vote_any   = |valid_vote;
        vote_one   = vote_any && ((valid_vote & (valid_vote - 4'd1)) == 4'd0);
        vote_multi = vote_any && !vote_one;
    end

    // Next-state and next-output decisions for every registered signal.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        scan_nxt    = scan_cnt;
        sel_nxt     = rd_sel;
        inc_nxt     = 4'd0;
        rej_nxt     = 1'b0;
        tmo_nxt     = 1'b0;
        ballots_nxt = ballots;

        case (state)
            ST_IDLE: begin
                // A button press with no ballot open is always flagged.
                rej_nxt = vote_any;
                if (mode) begin
                    state_nxt = ST_REVIEW;
                    scan_nxt  = 16'd0;
                    sel_nxt   = 2'd0;
                end else if (arm) begin
                    state_nxt = ST_ARMED;
                    timer_nxt = 16'd0;
                end
            end

            ST_ARMED: begin
                // Review request abandons the ballot outright, ahead of any vote.
                if (mode) begin
                    state_nxt = ST_REVIEW;
                    scan_nxt  = 16'd0;
                    sel_nxt   = 2'd0;
                end else if (vote_one) begin
                    // A legal vote wins even on the expiry cycle.
                    state_nxt = ST_COMMIT;
                    inc_nxt   = valid_vote;
                end else begin
                    rej_nxt = vote_multi;
                    if (timer == TMO_LAST) begin
                        tmo_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                        timer_nxt = 16'd0;
                    end else begin
                        timer_nxt = timer + 16'd1;
                    end
                end
            end

            ST_COMMIT: begin
                state_nxt = ST_LOCKED;
                if (ballots != 8'hFF) begin
                    ballots_nxt = ballots + 8'd1;
                end
            end

            ST_LOCKED: begin
                // Hold until the voter lets go of every button.
                if (valid_vote == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_REVIEW: begin
                if (!mode) begin
                    state_nxt = ST_IDLE;
                    scan_nxt  = 16'd0;
                    sel_nxt   = 2'd0;
                end else if (scan_cnt == SCAN_LAST) begin
                    scan_nxt = 16'd0;
                    sel_nxt  = rd_sel + 2'd1;
                end else begin
                    scan_nxt = scan_cnt + 16'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = 16'd0;
                scan_nxt  = 16'd0;
                sel_nxt   = 2'd0;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            timer        <= 16'd0;
            scan_cnt     <= 16'd0;
            vote_inc     <= 4'd0;
            ballot_ready <= 1'b0;
            reject       <= 1'b0;
            timeout      <= 1'b0;
            rd_sel       <= 2'd0;
            rd_valid     <= 1'b0;
            ballots      <= 8'd0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            scan_cnt     <= scan_nxt;
            vote_inc     <= inc_nxt;
            ballot_ready <= (state_nxt == ST_ARMED);
            reject       <= rej_nxt;
            timeout      <= tmo_nxt;
            rd_sel       <= sel_nxt;
            rd_valid     <= (state_nxt == ST_REVIEW);
            ballots      <= ballots_nxt;
        end
    end

endmodule

// File: tb/tb_ballot_controller.sv
// Bench for ballot_controller: directed scenarios plus randomized traffic,
// every cycle compared against a phase/age based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_ballot_controller;

    localparam int TMO  = 200;
    localparam int SCAN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       arm = 1'b0;
    logic [3:0] vv = 4'd0;
    logic [3:0] vote_inc;
    logic       ballot_ready;
    logic       reject;
    logic       timeout;
    logic [1:0] rd_sel;
    logic       rd_valid;
    logic [7:0] ballots;

    ballot_controller #(.TIMEOUT_CYCLES(TMO), .SCAN_CYCLES(SCAN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .arm         (arm),
        .valid_vote  (vv),
        .vote_inc    (vote_inc),
        .ballot_ready(ballot_ready),
        .reject      (reject),
        .timeout     (timeout),
        .rd_sel      (rd_sel),
        .rd_valid    (rd_valid),
        .ballots     (ballots)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what phase the ballot is in, and how long it has been there.
    typedef enum {P_IDLE, P_OPEN, P_CAST, P_HOLD, P_VIEW} phase_t;
    phase_t     ph = P_IDLE;
    int         open_age = 0;
    int         view_age = 0;
    int         n_cast = 0;
    logic [3:0] e_inc = 4'd0;
    logic       e_rej = 1'b0;
    logic       e_to = 1'b0;

    task automatic model_reset();
        ph = P_IDLE; open_age = 0; view_age = 0; n_cast = 0;
        e_inc = 4'd0; e_rej = 1'b0; e_to = 1'b0;
    endtask

    task automatic model_step();
        int n;
        n = $countones(vv);
        e_inc = 4'd0; e_rej = 1'b0; e_to = 1'b0;
        case (ph)
            P_IDLE: begin
                e_rej = (vv != 4'd0);
                if (mode) begin ph = P_VIEW; view_age = 0; end
                else if (arm) begin ph = P_OPEN; open_age = 0; end
            end
            P_OPEN: begin
                if (mode) begin ph = P_VIEW; view_age = 0; end
                else if (n == 1) begin ph = P_CAST; e_inc = vv; end
                else begin
                    e_rej = (n > 1);
                    if (open_age == TMO - 1) begin e_to = 1'b1; ph = P_IDLE; end
                    else open_age++;
                end
            end
            P_CAST: begin n_cast++; ph = P_HOLD; end
            P_HOLD: if (vv == 4'd0) ph = P_IDLE;
            P_VIEW: if (!mode) ph = P_IDLE; else view_age++;
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic compare_all();
        chk("vote_inc", 32'(vote_inc), 32'(e_inc));
        chk("reject", 32'(reject), 32'(e_rej));
        chk("timeout", 32'(timeout), 32'(e_to));
        chk("ballot_ready", 32'(ballot_ready), 32'(ph == P_OPEN));
        chk("rd_valid", 32'(rd_valid), 32'(ph == P_VIEW));
        chk("rd_sel", 32'(rd_sel), (ph == P_VIEW) ? 32'((view_age / SCAN) % 4) : 32'd0);
        chk("ballots", 32'(ballots), (n_cast > 255) ? 32'd255 : 32'(n_cast));
    endtask

    // One clock: DUT and model both take the edge, then outputs are compared.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (vote_inc != 4'd0) pulses++;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic reset_now();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vote_inc", 32'(vote_inc), 32'd0);
        chk("rst_ballots", 32'(ballots), 32'd0);
        chk("rst_ready", 32'(ballot_ready), 32'd0);
        chk("rst_flags", {29'd0, reject, timeout, rd_valid}, 32'd0);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int k;
    int to_at;
    logic [3:0] oh;

    initial begin
        // Reset state and first-arm acceptance.
        reset_now();

        // Held single vote: one increment, no reject, back to idle on release.
        arm = 1'b1; tick(); arm = 1'b0;
        vv = 4'b0010;
        pulses = 0;
        for (int i = 0; i < 20; i++) tick();
        vv = 4'b0000; tick(); tick();
        chk("r032_pulses", 32'(pulses), 32'd1);
        chk("r032_ballots", 32'(ballots), 32'd1);

        // Double press rejected while ballot stays open, then a legal vote.
        reset_now();
        arm = 1'b1; tick(); arm = 1'b0;
        vv = 4'b0110; tick();
        vv = 4'b0000; tick();
        chk("r033_ready", 32'(ballot_ready), 32'd1);
        vv = 4'b0100; tick();
        chk("r033_inc", 32'(vote_inc), 32'h4);
        vv = 4'b0000; tick(); tick();
        chk("r033_ballots", 32'(ballots), 32'd1);

        // Expiry with a stray arm part-way through that must not restart the timer.
        arm = 1'b1; tick(); arm = 1'b0;
        to_at = -1;
        for (k = 1; k <= 300 && to_at < 0; k++) begin
            arm = (k == 50);
            tick();
            if (timeout) to_at = k;
        end
        arm = 1'b0;
        chk("r034_timeout_cycle", 32'(to_at), 32'd200);
        chk("r034_ready", 32'(ballot_ready), 32'd0);
        chk("r034_ballots", 32'(ballots), 32'd1);

        // Idle presses rejected, then a review scan.
        vv = 4'b0001;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r035_reject", 32'(reject), 32'd1);
        end
        vv = 4'b0000; tick();
        chk("r035_inc_pulses", 32'(pulses), 32'd0);
        mode = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if ((i - 1) % 16 == 0) chk("r035_rd_sel", 32'(rd_sel), 32'(((i - 1) / 16) % 4));
        end
        mode = 1'b0; tick();
        chk("r035_sel_exit", 32'(rd_sel), 32'd0);

        // Saturating tally over 256 ballots.
        reset_now();
        pulses = 0;
        for (int b = 0; b < 256; b++) begin
            arm = 1'b1; tick(); arm = 1'b0;
            oh = 4'b0001 << $urandom_range(0, 3);
            vv = oh; tick();
            vv = 4'b0000; tick(); tick();
        end
        chk("r036_pulses", 32'(pulses), 32'd256);
        chk("r036_ballots", 32'(ballots), 32'd255);

        // Reset landing in the commit cycle loses the vote.
        reset_now();
        arm = 1'b1; tick(); arm = 1'b0;
        vv = 4'b1000; tick();
        chk("r037_inc_before", 32'(vote_inc), 32'h8);
        vv = 4'b0000;
        reset_now();
        chk("r037_ballots", 32'(ballots), 32'd0);
        vv = 4'b0001; tick();
        chk("r037_idle_reject", 32'(reject), 32'd1);
        vv = 4'b0000; tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            arm = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0, 1: vv = 4'b0001 << $urandom_range(0, 3);
                2:    vv = 4'($urandom_range(0, 15));
                default: vv = 4'b0000;
            endcase
            if ($urandom_range(0, 599) == 0) reset_now();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
